// File: rtl/scroll_text_buffer_if.sv
// ---------------------------------------------------------------------------
// scroll_text_buffer_if
//
// Purpose : Groups the command inputs and display/status outputs of the
//           scrolling seven-segment text buffer into one bundle.
//
// Signals : sym       7-bit segment pattern of the character to push
//           push      insert sym as the newest character
//           pop       delete the newest character (backspace)
//           clr       erase all stored characters
//           scroll_l  move the view one character toward older text
//           scroll_r  move the view one character toward newer text
//           buffer    displayed digits, buffer[0] is the rightmost digit
//           count     number of stored characters
//           offset    current view offset
//           full      count == DEPTH
//           empty     count == 0
//           overflow  one-cycle pulse on a rejected or overwriting push
//
// Modports: master drives the commands and observes the display;
//           slave is the buffer itself.
// ---------------------------------------------------------------------------
interface scroll_text_buffer_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [6:0]             sym;
    logic                   push;
    logic                   pop;
    logic                   clr;
    logic                   scroll_l;
    logic                   scroll_r;
    logic [WIDTH-1:0][6:0]  buffer;
    logic [CW-1:0]          count;
    logic [CW-1:0]          offset;
    logic                   full;
    logic                   empty;
    logic                   overflow;

    modport master (
        output sym, push, pop, clr, scroll_l, scroll_r,
        input  buffer, count, offset, full, empty, overflow
    );

    modport slave (
        input  sym, push, pop, clr, scroll_l, scroll_r,
        output buffer, count, offset, full, empty, overflow
    );
endinterface

// File: rtl/scroll_text_buffer.sv
// ---------------------------------------------------------------------------
// scroll_text_buffer
//
// Purpose : Stores up to DEPTH seven-segment characters (newest in slot 0)
//           and presents a WIDTH-digit window onto them that can be scrolled
//           toward older text. Supports push, backspace (pop), replace-newest
//           (push+pop), clear and a configurable full policy.
//
// Ports   : clk    rising-edge clock
//           reset  synchronous, active-high
//           bus    scroll_text_buffer_if.slave (commands in, display out)
//
// Params  : WIDTH      displayed digits (>= 1)
//           DEPTH      stored characters (>= WIDTH)
//           OVERWRITE  1: push when full drops the oldest character
//                      0: push when full is rejected
//           BLANK      segment pattern of an unused slot (active-low, all off)
// ---------------------------------------------------------------------------
module scroll_text_buffer #(
    parameter int         WIDTH     = 6,
    parameter int         DEPTH     = 16,
    parameter int         OVERWRITE = 1,
    parameter logic [6:0] BLANK     = 7'b1111111
) (
    input  logic                  clk,
    input  logic                  reset,
    scroll_text_buffer_if.slave   bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    // One decoded action per edge; the decode encodes the command priority
    // clr > push/pop > scroll, so the register process only executes it.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLEAR,
        OP_SHIFT_IN,
        OP_REPLACE,
        OP_SHIFT_OUT,
        OP_REJECT,
        OP_SCROLL_L,
        OP_SCROLL_R
    } op_e;

    logic [6:0]            mem [DEPTH];
    logic [CW-1:0]         count;
    logic [CW-1:0]         offset;
    logic [CW-1:0]         max_offset;
    logic                  overflow_q;
    logic                  full;
    logic                  empty;
    logic [WIDTH-1:0][6:0] disp;
    op_e                   op;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    // The window may not scroll past the oldest character; with fewer
    // characters than digits there is nothing to scroll to.
    assign max_offset = (count > WIDTH_C) ? (count - WIDTH_C) : '0;

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        op = OP_IDLE;
        if (bus.clr) begin
            op = OP_CLEAR;
        end else if (bus.push && bus.pop && !empty) begin
            op = OP_REPLACE;
        end else if (bus.push) begin
            // Push+pop on an empty buffer lands here and acts as a plain push.
            if (!full || (OVERWRITE != 0)) op = OP_SHIFT_IN;
            else                           op = OP_REJECT;
        end else if (bus.pop) begin
            // A pop on an empty buffer is ignored; it still outranks scroll,
            // though with no characters the offset is pinned at 0 anyway.
            if (!empty) op = OP_SHIFT_OUT;
        end else if (bus.scroll_l && !bus.scroll_r) begin
            if (offset < max_offset) op = OP_SCROLL_L;
        end else if (bus.scroll_r && !bus.scroll_l) begin
            if (offset != '0) op = OP_SCROLL_R;
        end
    end

    // -----------------------------------------------------------------------
    // Storage, count, offset and overflow pulse
    // -----------------------------------------------------------------------
    // NOTE: the character slots are reset because unused slots must read
    // BLANK; without that reset the display would show garbage after reset.
    // NOTE: state is updated with non-blocking assignments so the shift
    // loops read the pre-edge contents of every slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= BLANK;
            count      <= '0;
            offset     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            unique case (op)
                OP_CLEAR: begin
                    for (int k = 0; k < DEPTH; k++) mem[k] <= BLANK;
                    count  <= '0;
                    offset <= '0;
                end
                OP_SHIFT_IN: begin
                    // When full, the oldest character falls off the end.
                    for (int k = DEPTH - 1; k > 0; k--) mem[k] <= mem[k-1];
                    mem[0] <= bus.sym;
                    offset <= '0;
                    if (full) overflow_q <= 1'b1;
                    else      count      <= count + CW'(1);
                end
                OP_REPLACE: begin
                    mem[0] <= bus.sym;
                    offset <= '0;
                end
                OP_SHIFT_OUT: begin
                    for (int k = 0; k < DEPTH - 1; k++) mem[k] <= mem[k+1];
                    mem[DEPTH-1] <= BLANK;
                    count        <= count - CW'(1);
                    offset       <= '0;
                end
                OP_REJECT: begin
                    // Contents, count and view are all left untouched.
                    overflow_q <= 1'b1;
                end
                OP_SCROLL_L: offset <= offset + CW'(1);
                OP_SCROLL_R: offset <= offset - CW'(1);
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Display window: digit j shows slot offset+j, BLANK past the last slot.
    // Written as a compare-select over constant slot indices so no variable
    // index ever leaves the storage range.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            disp[j] = BLANK;
            for (int k = 0; k < DEPTH; k++) begin
                if (k == int'(offset) + j) disp[j] = mem[k];
            end
        end
    end

    assign bus.buffer   = disp;
    assign bus.count    = count;
    assign bus.offset   = offset;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_scroll_text_buffer.sv
// ---------------------------------------------------------------------------
// tb_scroll_text_buffer
//
// Drives two buffers (OVERWRITE=1 and OVERWRITE=0) with the same directed
// command sequence. A queue-based model of the text tracks each one and a
// compare process checks every output on every falling edge; literal checks
// in the stimulus pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_scroll_text_buffer;
    localparam int         W     = 6;
    localparam int         D     = 16;
    localparam int         CW    = $clog2(D + 1);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] CH_A  = 7'h08;
    localparam logic [6:0] CH_B  = 7'h03;
    localparam logic [6:0] CH_C  = 7'h46;

    typedef logic [6:0] char_q_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] sym;
    logic       push, pop, clr, scroll_l, scroll_r;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scroll_text_buffer_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
    scroll_text_buffer_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    assign bus0.sym = sym;  assign bus1.sym = sym;
    assign bus0.push = push;  assign bus1.push = push;
    assign bus0.pop = pop;  assign bus1.pop = pop;
    assign bus0.clr = clr;  assign bus1.clr = clr;
    assign bus0.scroll_l = scroll_l;  assign bus1.scroll_l = scroll_l;
    assign bus0.scroll_r = scroll_r;  assign bus1.scroll_r = scroll_r;

    scroll_text_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1), .BLANK(BLANK)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    scroll_text_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0), .BLANK(BLANK)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // ---------------- model: text as a queue, newest at index 0 -------------
    char_q_t q0, q1;
    int      off0 = 0, off1 = 0;
    bit      ovf0 = 1'b0, ovf1 = 1'b0;

    task automatic model_update(input int ow, inout char_q_t q, inout int off, inout bit ovf);
        int lim;
        ovf = 1'b0;
        if (reset || clr) begin
            q.delete();
            off = 0;
        end else if (push || pop) begin
            if (push && pop && q.size() > 0) begin
                q[0] = sym;
                off  = 0;
            end else if (push) begin
                if (q.size() < D) begin
                    q.push_front(sym);
                    off = 0;
                end else if (ow != 0) begin
                    void'(q.pop_back());
                    q.push_front(sym);
                    off = 0;
                    ovf = 1'b1;
                end else begin
                    ovf = 1'b1;
                end
            end else if (q.size() > 0) begin
                void'(q.pop_front());
                off = 0;
            end
        end else if (scroll_l && !scroll_r) begin
            lim = (q.size() > W) ? q.size() - W : 0;
            if (off < lim) off++;
        end else if (scroll_r && !scroll_l) begin
            if (off > 0) off--;
        end
    endtask

    function automatic logic [W*7-1:0] exp_buf(input char_q_t q, input int off);
        logic [W*7-1:0] r;
        for (int j = 0; j < W; j++)
            r[j*7 +: 7] = (off + j < q.size()) ? q[off + j] : BLANK;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        model_update(1, q0, off0, ovf0);
        model_update(0, q1, off1, ovf1);
    end

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input string tag, input logic [W*7-1:0] b,
                                input logic [CW-1:0] cnt, input logic [CW-1:0] off,
                                input logic fl, input logic em, input logic ov,
                                input char_q_t q, input int moff, input bit movf);
        check({tag, ".buffer"},   64'(b),   64'(exp_buf(q, moff)));
        check({tag, ".count"},    64'(cnt), 64'(q.size()));
        check({tag, ".offset"},   64'(off), 64'(moff));
        check({tag, ".full"},     64'(fl),  64'(q.size() == D));
        check({tag, ".empty"},    64'(em),  64'(q.size() == 0));
        check({tag, ".overflow"}, 64'(ov),  64'(movf));
    endtask

    initial forever begin
        @(negedge clk);
        compare_inst("ow1", bus0.buffer, bus0.count, bus0.offset, bus0.full,
                     bus0.empty, bus0.overflow, q0, off0, ovf0);
        compare_inst("ow0", bus1.buffer, bus1.count, bus1.offset, bus1.full,
                     bus1.empty, bus1.overflow, q1, off1, ovf1);
    end

    // ---------------- stimulus ----------------------------------------------
    function automatic logic [6:0] chr(input int i);
        return 7'(8'h10 + i);
    endfunction

    task automatic idle_inputs();
        sym = '0; push = 0; pop = 0; clr = 0; scroll_l = 0; scroll_r = 0; reset = 0;
    endtask

    // Apply one cycle of commands; returns just after the following falling
    // edge, when the post-edge outputs are settled.
    task automatic step(input logic [6:0] s, input bit pu, input bit po, input bit cl,
                        input bit sl, input bit sr, input bit rs);
        sym = s; push = pu; pop = po; clr = cl; scroll_l = sl; scroll_r = sr; reset = rs;
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_push(input logic [6:0] s); step(s, 1, 0, 0, 0, 0, 0); endtask
    task automatic do_pop();  step('0, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_clr();  step('0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_sl();   step('0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_sr();   step('0, 0, 0, 0, 0, 1, 0); endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        step('0, 0, 0, 0, 0, 0, 1);

        // Reset state
        check("rst.count",  64'(bus0.count), 64'd0);
        check("rst.empty",  64'(bus0.empty), 64'd1);
        check("rst.full",   64'(bus0.full),  64'd0);
        check("rst.buffer", 64'(bus0.buffer), {22'd0, {W{BLANK}}});

        // Push A, B, C
        do_push(CH_A); do_push(CH_B); do_push(CH_C);
        check("abc.count", 64'(bus0.count), 64'd3);
        check("abc.d0", 64'(bus0.buffer[0]), 64'(CH_C));
        check("abc.d1", 64'(bus0.buffer[1]), 64'(CH_B));
        check("abc.d2", 64'(bus0.buffer[2]), 64'(CH_A));
        check("abc.d5", 64'(bus0.buffer[5]), 64'(BLANK));
        check("abc.model", 64'(q0.size()), 64'd3);

        // Fill to 16, then one more push
        for (int i = 3; i < 16; i++) do_push(chr(i));
        check("fill.full", 64'(bus1.full), 64'd1);
        do_push(chr(16));
        check("ovf.ow1", 64'(bus0.overflow), 64'd1);
        check("ovf.ow0", 64'(bus1.overflow), 64'd1);
        check("ovf.cnt1", 64'(bus0.count), 64'd16);
        check("ovf.new1", 64'(bus0.buffer[0]), 64'(chr(16)));
        check("ovf.keep0", 64'(bus1.buffer[0]), 64'(chr(15)));
        step('0, 0, 0, 0, 0, 0, 0);
        check("ovf.pulse1", 64'(bus0.overflow), 64'd0);
        check("ovf.pulse0", 64'(bus1.overflow), 64'd0);

        // View the oldest text: A lost with overwrite, kept without
        for (int i = 0; i < 11; i++) do_sl();
        check("old.off", 64'(bus0.offset), 64'd10);
        check("old.ow1", 64'(bus0.buffer[5]), 64'(CH_B));
        check("old.ow0", 64'(bus1.buffer[5]), 64'(CH_A));
        do_push(chr(17));
        check("rej.off0", 64'(bus1.offset), 64'd10);
        check("rej.off1", 64'(bus0.offset), 64'd0);

        // Scroll saturation with ten characters
        do_clr();
        for (int i = 0; i < 10; i++) do_push(chr(20 + i));
        for (int i = 0; i < 6; i++) do_sl();
        check("sl.sat", 64'(bus0.offset), 64'd4);
        check("sl.d0", 64'(bus0.buffer[0]), 64'(chr(25)));
        for (int i = 0; i < 5; i++) do_sr();
        check("sr.sat", 64'(bus0.offset), 64'd0);
        do_sl(); do_sl();
        step('0, 0, 0, 0, 1, 1, 0);
        check("both.off", 64'(bus0.offset), 64'd2);

        // Backspace past empty, then replace-newest
        do_clr();
        do_push(chr(1)); do_push(chr(2)); do_push(chr(3));
        for (int i = 0; i < 4; i++) do_pop();
        check("pop.count", 64'(bus0.count), 64'd0);
        check("pop.empty", 64'(bus0.empty), 64'd1);
        check("pop.buffer", 64'(bus0.buffer), {22'd0, {W{BLANK}}});
        do_push(chr(1)); do_push(chr(2));
        step(chr(9), 1, 1, 0, 0, 0, 0);
        check("rep.count", 64'(bus0.count), 64'd2);
        check("rep.d0", 64'(bus0.buffer[0]), 64'(chr(9)));
        check("rep.d1", 64'(bus0.buffer[1]), 64'(chr(1)));

        // Push snaps the view home; clr beats push
        for (int i = 0; i < 8; i++) do_push(chr(40 + i));
        for (int i = 0; i < 3; i++) do_sl();
        check("home.pre", 64'(bus0.offset), 64'd3);
        do_push(chr(30));
        check("home.off", 64'(bus0.offset), 64'd0);
        check("home.d0", 64'(bus0.buffer[0]), 64'(chr(30)));
        step(chr(31), 1, 0, 1, 0, 0, 0);
        check("clrpush.count", 64'(bus0.count), 64'd0);
        check("clrpush.buffer", 64'(bus0.buffer), {22'd0, {W{BLANK}}});

        // Reset beats a push mid-operation
        for (int i = 0; i < 5; i++) do_push(chr(50 + i));
        check("pre_rst.count", 64'(bus0.count), 64'd5);
        step(chr(60), 1, 0, 0, 0, 0, 1);
        check("rst2.count", 64'(bus0.count), 64'd0);
        check("rst2.empty", 64'(bus0.empty), 64'd1);
        check("rst2.offset", 64'(bus0.offset), 64'd0);
        check("rst2.buffer", 64'(bus0.buffer), {22'd0, {W{BLANK}}});

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
